// File: rtl/hazard_ctrl_if.sv
// Purpose : bundles the ID/EX operand, memory and branch status seen by the hazard unit, plus its control outputs.
// Latency : wires only; no storage.
// Backpressure: none here; stall/freeze outputs carry backpressure to the pipeline.
// Ports   : master = pipeline side (drives operand/status, receives controls);
//           slave  = hazard_ctrl side (receives operand/status, drives controls).
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] ex_wr;
  logic              ex_we;
  logic              ex_is_load;
  logic              branch_taken;
  logic              mem_busy;
  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              freeze;
  logic [1:0]        hazard_state;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_wr, ex_we, ex_is_load, branch_taken, mem_busy,
    input  stall_pc, stall_if_id, flush_if_id, flush_id_ex, freeze, hazard_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_wr, ex_we, ex_is_load, branch_taken, mem_busy,
    output stall_pc, stall_if_id, flush_if_id, flush_id_ex, freeze, hazard_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard controller: load-use bubbles, branch flushes, memory-wait freeze.
// Latency : all controls combinational from inputs and state; hazard_state is the registered FSM state.
// Backpressure: mem_busy freezes the whole pipeline and suspends any load-use stall in progress.
// Ports   : clk, rst (sync, active-high); hz (hazard_ctrl_if.slave) carries ID/EX operands,
//           branch_taken, mem_busy and the stall/flush/freeze/hazard_state outputs.
//           Optional macro HAZARD_STAT_EN adds stall_cycles, flush_events, freeze_cycles (STAT_W wide).
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_if.slave      hz
`ifdef HAZARD_STAT_EN
  ,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events,
  output logic [STAT_W-1:0] freeze_cycles
`endif
);

  if (REG_AW < 1 || LOAD_LAT < 1 || LOAD_LAT > 4 || STAT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: illegal parameter value");
  end

  // Smallest width holding LOAD_LAT-1, never below one bit.
  localparam int CNT_W = (LOAD_LAT <= 2) ? 1 : $clog2(LOAD_LAT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  state_e           sav_state_q, sav_state_d;
  state_e           eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sav_cnt_q, sav_cnt_d;
  logic [CNT_W-1:0] eff_cnt;

  logic [REG_AW-1:0] rs1, rs2, wr;
  logic              ld_hit;
  logic              stall_o, flush_if_o, flush_ex_o, freeze_o;

  assign rs1 = hz.id_rs1;
  assign rs2 = hz.id_rs2;
  assign wr  = hz.ex_wr;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  always_comb begin
    ld_hit = hz.ex_is_load & hz.ex_we & (wr != '0) &
             ((hz.id_rs1_used & (rs1 == wr)) | (hz.id_rs2_used & (rs2 == wr)));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sav_state_d = sav_state_q;
    sav_cnt_d   = sav_cnt_q;
    stall_o     = 1'b0;
    flush_if_o  = 1'b0;
    flush_ex_o  = 1'b0;
    freeze_o    = 1'b0;

    // Leaving MEM_WAIT resumes the suspended state this very cycle.
    eff_state = state_q;
    eff_cnt   = cnt_q;
    if (state_q == MEM_WAIT) begin
      eff_state = sav_state_q;
      eff_cnt   = sav_cnt_q;
    end

    if (hz.mem_busy) begin
      freeze_o = 1'b1;
      state_d  = MEM_WAIT;
      // Only capture on entry; while waiting the saved context must survive.
      if (state_q != MEM_WAIT) begin
        sav_state_d = state_q;
        sav_cnt_d   = cnt_q;
      end
    end else if (hz.branch_taken) begin
      // Wrong-path instructions are discarded, so any pending load bubble is moot.
      flush_if_o = 1'b1;
      flush_ex_o = 1'b1;
      state_d    = IDLE;
      cnt_d      = '0;
    end else if (eff_state == LD_STALL) begin
      stall_o    = 1'b1;
      flush_ex_o = 1'b1;
      if (eff_cnt == CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = LD_STALL;
        cnt_d   = eff_cnt - CNT_W'(1);
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
      if (ld_hit) begin
        stall_o    = 1'b1;
        flush_ex_o = 1'b1;
        if (LOAD_LAT > 1) begin
          state_d = LD_STALL;
          cnt_d   = CNT_W'(LOAD_LAT - 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sav_state_q <= IDLE;
      sav_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sav_state_q <= sav_state_d;
      sav_cnt_q   <= sav_cnt_d;
    end
  end

  assign hz.stall_pc     = stall_o;
  assign hz.stall_if_id  = stall_o;
  assign hz.flush_if_id  = flush_if_o;
  assign hz.flush_id_ex  = flush_ex_o;
  assign hz.freeze       = freeze_o;
  assign hz.hazard_state = state_q;

`ifdef HAZARD_STAT_EN
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [STAT_W-1:0] flush_events_q, flush_events_d;
  logic [STAT_W-1:0] freeze_cycles_q, freeze_cycles_d;

  // Counters wrap naturally at 2^STAT_W.
  always_comb begin
    stall_cycles_d  = stall_cycles_q  + STAT_W'(stall_o);
    flush_events_d  = flush_events_q  + STAT_W'(flush_if_o);
    freeze_cycles_d = freeze_cycles_q + STAT_W'(freeze_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q  <= '0;
      flush_events_q  <= '0;
      freeze_cycles_q <= '0;
    end else begin
      stall_cycles_q  <= stall_cycles_d;
      flush_events_q  <= flush_events_d;
      freeze_cycles_q <= freeze_cycles_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign flush_events  = flush_events_q;
  assign freeze_cycles = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(AW)) if1 ();
  hazard_ctrl_if #(.REG_AW(AW)) if3 ();

`ifdef HAZARD_STAT_EN
  logic [SW-1:0] sc1, fe1, fz1, sc3, fe3, fz3;
`endif

  hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(1), .STAT_W(SW)) u_lat1 (
    .clk(clk), .rst(rst), .hz(if1)
`ifdef HAZARD_STAT_EN
    , .stall_cycles(sc1), .flush_events(fe1), .freeze_cycles(fz1)
`endif
  );

  hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(3), .STAT_W(SW)) u_lat3 (
    .clk(clk), .rst(rst), .hz(if3)
`ifdef HAZARD_STAT_EN
    , .stall_cycles(sc3), .flush_events(fe3), .freeze_cycles(fz3)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] wr;
    logic          we;
    logic          ld;
    logic          br;
    logic          mb;
    logic          r;
  } in_t;

  // Output order: {stall_pc, stall_if_id, flush_if_id, flush_id_ex, freeze}
  typedef struct packed {
    logic [1:0][4:0]    o;
    logic [1:0][1:0]    st;
    logic [1:0][SW-1:0] sc;
    logic [1:0][SW-1:0] fe;
    logic [1:0][SW-1:0] fz;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  // Reference model: bubbles still owed after this cycle, and whether a memory wait is open.
  int            lat[2] = '{1, 3};
  int            rem[2];
  bit            waiting[2];
  logic [SW-1:0] m_sc[2], m_fe[2], m_fz[2];

  logic [4:0] act_o[2];
  logic [1:0] act_st[2];
  assign act_o[0]  = {if1.stall_pc, if1.stall_if_id, if1.flush_if_id, if1.flush_id_ex, if1.freeze};
  assign act_o[1]  = {if3.stall_pc, if3.stall_if_id, if3.flush_if_id, if3.flush_id_ex, if3.freeze};
  assign act_st[0] = if1.hazard_state;
  assign act_st[1] = if3.hazard_state;

  function automatic bit is_hit(input in_t s);
    return s.ld && s.we && (s.wr != 0) &&
           ((s.u1 && s.rs1 == s.wr) || (s.u2 && s.rs2 == s.wr));
  endfunction

  task automatic drive(input in_t s);
    if1.id_rs1 = s.rs1; if1.id_rs2 = s.rs2; if1.id_rs1_used = s.u1; if1.id_rs2_used = s.u2;
    if1.ex_wr = s.wr; if1.ex_we = s.we; if1.ex_is_load = s.ld;
    if1.branch_taken = s.br; if1.mem_busy = s.mb;
    if3.id_rs1 = s.rs1; if3.id_rs2 = s.rs2; if3.id_rs1_used = s.u1; if3.id_rs2_used = s.u2;
    if3.ex_wr = s.wr; if3.ex_we = s.we; if3.ex_is_load = s.ld;
    if3.branch_taken = s.br; if3.mem_busy = s.mb;
    rst = s.r;
  endtask

  task automatic cycle(input in_t s);
    exp_t e;
    @(posedge clk);
    #1;
    drive(s);
    e = '0;
    for (int i = 0; i < 2; i++) begin
      if (s.mb)              e.o[i] = 5'b00001;
      else if (s.br)         e.o[i] = 5'b00110;
      else if (rem[i] > 0)   e.o[i] = 5'b11010;
      else if (is_hit(s))    e.o[i] = 5'b11010;
      else                   e.o[i] = 5'b00000;
      e.st[i] = waiting[i] ? 2'd2 : ((rem[i] > 0) ? 2'd1 : 2'd0);
      e.sc[i] = m_sc[i];
      e.fe[i] = m_fe[i];
      e.fz[i] = m_fz[i];
    end
    q.push_back(e);
    for (int i = 0; i < 2; i++) begin
      if (s.r) begin
        rem[i] = 0; waiting[i] = 1'b0;
        m_sc[i] = '0; m_fe[i] = '0; m_fz[i] = '0;
      end else begin
        m_sc[i] = m_sc[i] + SW'(e.o[i][3]);
        m_fe[i] = m_fe[i] + SW'(e.o[i][2]);
        m_fz[i] = m_fz[i] + SW'(e.o[i][0]);
        if (s.mb) begin
          waiting[i] = 1'b1;
        end else begin
          waiting[i] = 1'b0;
          if (s.br)             rem[i] = 0;
          else if (rem[i] > 0)  rem[i] = rem[i] - 1;
          else if (is_hit(s))   rem[i] = lat[i] - 1;
        end
      end
    end
  endtask

  function automatic in_t mk(input int rs1, input int u1, input int rs2, input int u2,
                             input int wr, input int we, input int ld,
                             input int br, input int mb, input int r);
    in_t s;
    s.rs1 = AW'(rs1); s.u1 = u1[0]; s.rs2 = AW'(rs2); s.u2 = u2[0];
    s.wr = AW'(wr); s.we = we[0]; s.ld = ld[0]; s.br = br[0]; s.mb = mb[0]; s.r = r[0];
    return s;
  endfunction

  // Monitor: compares each presented output set against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (act_o[i] !== e.o[i]) begin
            errors++;
            $display("FAIL ctrl_outs lat%0d: got %b want %b", lat[i], act_o[i], e.o[i]);
          end
          checks++;
          if (act_st[i] !== e.st[i]) begin
            errors++;
            $display("FAIL hazard_state lat%0d: got %0d want %0d", lat[i], act_st[i], e.st[i]);
          end
`ifdef HAZARD_STAT_EN
          checks++;
          if ((i == 0 ? sc1 : sc3) !== e.sc[i] || (i == 0 ? fe1 : fe3) !== e.fe[i] ||
              (i == 0 ? fz1 : fz3) !== e.fz[i]) begin
            errors++;
            $display("FAIL stats lat%0d: got %0d/%0d/%0d want %0d/%0d/%0d", lat[i],
                     (i == 0 ? sc1 : sc3), (i == 0 ? fe1 : fe3), (i == 0 ? fz1 : fz3),
                     e.sc[i], e.fe[i], e.fz[i]);
          end
`endif
        end
      end
    end
  end

  initial begin
    in_t s;
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; waiting[i] = 1'b0; m_sc[i] = '0; m_fe[i] = '0; m_fz[i] = '0;
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (2) @(posedge clk);

    // Reset state with quiet inputs.
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Load-use on x5 via rs1, then quiet cycles to watch the bubble train drain.
    cycle(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0));
    repeat (4) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Load to x0, and an unused-operand match: no stall.
    cycle(mk(0, 1, 0, 1, 0, 1, 1, 0, 0, 0));
    cycle(mk(7, 0, 3, 1, 7, 1, 1, 0, 0, 0));
    // Hit via rs2.
    cycle(mk(1, 1, 9, 1, 9, 1, 1, 0, 0, 0));
    repeat (3) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Memory wait in the middle of a load stall.
    cycle(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, 0));
    repeat (2) cycle(mk(5, 1, 0, 0, 5, 1, 1, 0, 1, 0));
    repeat (4) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Branch together with a hit, then branch aborting a stall.
    cycle(mk(5, 1, 0, 0, 5, 1, 1, 1, 0, 0));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(6, 1, 0, 0, 6, 1, 1, 0, 0, 0));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    repeat (2) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Reset mid-stall: no residual bubble.
    cycle(mk(4, 1, 0, 0, 4, 1, 1, 0, 0, 0));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (2) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Seventeen consecutive stall cycles wrap a 4-bit counter, then reset clears it.
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (17) cycle(mk(3, 1, 0, 0, 3, 1, 1, 0, 0, 0));
    repeat (3) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Randomized traffic over a small register window so hits are frequent.
    for (int n = 0; n < 3000; n++) begin
      s.rs1 = AW'($urandom_range(0, 3));
      s.rs2 = AW'($urandom_range(0, 3));
      s.wr  = AW'($urandom_range(0, 3));
      s.u1  = ($urandom_range(0, 3) != 0);
      s.u2  = ($urandom_range(0, 1) != 0);
      s.we  = ($urandom_range(0, 7) != 0);
      s.ld  = ($urandom_range(0, 1) != 0);
      s.br  = ($urandom_range(0, 9) == 0);
      s.mb  = ($urandom_range(0, 6) == 0);
      s.r   = ($urandom_range(0, 99) == 0);
      cycle(s);
    end

    stim_done = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
